// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO page location,
// word offsets of the MMIO registers and the STATUS register layout.
package dmem_pkg;

  // Value of address_dmem[31:12] that selects the MMIO page.
  localparam logic [19:0] MMIO_PAGE_DEFAULT = 20'hFFFFF;

  // Word offsets inside the MMIO page (address_dmem[11:0]).
  localparam logic [11:0] MMIO_TXDATA = 12'h000;
  localparam logic [11:0] MMIO_STATUS = 12'h001;
  localparam logic [11:0] MMIO_CYCLES = 12'h002;
  localparam logic [11:0] MMIO_DROPS  = 12'h003;

  // STATUS register layout.
  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 8;

endpackage

// File: rtl/console_fifo.sv
// Byte-wide console transmit FIFO. Circular buffer with wrapping read/write
// pointers and an explicit occupancy count. The head is presented from
// registered storage; a push into an empty FIFO becomes visible one cycle
// later (no bypass). A pop frees a slot in the same cycle, so a push that
// coincides with a pop is accepted even when the FIFO is full.
module console_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop_ready,
  output logic [7:0]              head,
  output logic                    valid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          pop;
  logic          push_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == FULL_COUNT);
  assign pop     = valid && pop_ready;
  assign push_ok = push && (!full || pop);
  assign head    = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count   = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; reset empties the FIFO and drops any same-cycle push.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; contents are meaningless while empty so it is not cleared.
  always_ff @(posedge clock) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the processor data-memory port. Decodes the word address
// into RAM, the MMIO page (console FIFO, cycle counter, dropped-write
// counter) or unmapped space. Reads are combinational with no wait states;
// writes take effect on the rising clock edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [19:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           ram_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  is_ram;
  logic                  is_mmio;
  logic [11:0]           mmio_off;

  logic                  mmio_wr;
  logic                  tx_push;
  logic                  cycles_wr;
  logic                  drops_clr;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic                  drop_evt;

  logic [31:0]           cycles_q, cycles_d;
  logic [31:0]           drops_q, drops_d;
  logic [31:0]           status_word;

  assign is_ram   = ((address_dmem >> ADDR_WIDTH) == 32'd0);
  assign is_mmio  = (address_dmem[31:12] == MMIO_PAGE);
  assign ram_addr = address_dmem[ADDR_WIDTH-1:0];
  assign mmio_off = address_dmem[11:0];

  // MMIO stores are suppressed while reset is asserted; RAM stores are not.
  assign mmio_wr   = reset && wren && is_mmio;
  assign tx_push   = mmio_wr && (mmio_off == MMIO_TXDATA);
  assign cycles_wr = mmio_wr && (mmio_off == MMIO_CYCLES);
  assign drops_clr = mmio_wr && (mmio_off == MMIO_DROPS);

  // A push is only dropped when full and no pop frees a slot this cycle.
  assign fifo_pop  = io_valid && io_ready;
  assign drop_evt  = tx_push && fifo_full && !fifo_pop;

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (data[7:0]),
    .pop_ready (io_ready),
    .head      (io_data),
    .valid     (io_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // RAM store; a same-cycle read still sees the old word.
  always_ff @(posedge clock) begin
    if (wren && is_ram) begin
      ram_q[ram_addr] <= data;
    end
  end

  // Counter next-state: a CYCLES store wins over the increment, DROPS saturates.
  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (cycles_wr) begin
      cycles_d = data;
    end
    drops_d = drops_q;
    if (drops_clr) begin
      drops_d = 32'd0;
    end else if (drop_evt && (drops_q != 32'hFFFF_FFFF)) begin
      drops_d = drops_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycles_q <= 32'd0;
      drops_q  <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
      drops_q  <= drops_d;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word = 32'd0;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = !io_valid;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  // Combinational read mux; unmapped space and unused offsets read as zero.
  always_comb begin
    q_dmem = 32'd0;
    if (is_ram) begin
      q_dmem = ram_q[ram_addr];
    end else if (is_mmio) begin
      case (mmio_off)
        MMIO_TXDATA: q_dmem = {24'd0, io_data};
        MMIO_STATUS: q_dmem = status_word;
        MMIO_CYCLES: q_dmem = cycles_q;
        MMIO_DROPS:  q_dmem = drops_q;
        default:     q_dmem = 32'd0;
      endcase
    end
  end

endmodule
